// File: rtl/calc_entry_fsm.sv
// Calculator entry core: assembles decimal operands from keypad strobes,
// applies + - x and drives a registered value toward bin2bcd_10bit.
// Ports:
//   Clk           system clock
//   reset         synchronous active-high reset
//   key_valid     one-cycle strobe qualifying keycode
//   keycode       0-9 digit, A add, B sub, C mul, D CE, E equals, F AC
//   display_value value shown on the BCD/seven-segment path
//   error         high while in the error state
//   op_pending    stored operator (0 none, 1 add, 2 sub, 3 mul)
//   key_ack       one-cycle pulse after every accepted strobe
module calc_entry_fsm #(
  parameter int unsigned MAX_DIGITS = 3,
  parameter int unsigned MAX_VALUE  = 999,
  parameter int unsigned WIDTH      = 10
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             key_valid,
  input  logic [3:0]       keycode,
  output logic [WIDTH-1:0] display_value,
  output logic             error,
  output logic [1:0]       op_pending,
  output logic             key_ack
);

  localparam int unsigned LW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(MAX_DIGITS + 1);

  localparam logic [2:0] S_ENTRY_A = 3'd0;
  localparam logic [2:0] S_OP_PEND = 3'd1;
  localparam logic [2:0] S_ENTRY_B = 3'd2;
  localparam logic [2:0] S_RESULT  = 3'd3;
  localparam logic [2:0] S_ERROR   = 3'd4;

  logic [2:0]       r_state;
  logic [WIDTH-1:0] r_acc_a;
  logic [WIDTH-1:0] r_acc_b;
  logic [CW-1:0]    r_digit_cnt;
  logic [1:0]       r_op;

  logic [2:0]       w_nxt_state;
  logic [WIDTH-1:0] w_nxt_acc_a;
  logic [WIDTH-1:0] w_nxt_acc_b;
  logic [CW-1:0]    w_nxt_cnt;
  logic [1:0]       w_nxt_op;
  logic [WIDTH-1:0] w_nxt_display;
  logic             w_nxt_error;
  logic [1:0]       w_nxt_op_pending;

  // Key classification
  logic       w_is_digit, w_is_op, w_is_ce, w_is_eq, w_is_ac;
  logic [1:0] w_key_op;
  assign w_is_digit = (keycode <= 4'd9);
  assign w_is_op    = (keycode >= 4'hA) && (keycode <= 4'hC);
  assign w_is_ce    = (keycode == 4'hD);
  assign w_is_eq    = (keycode == 4'hE);
  assign w_is_ac    = (keycode == 4'hF);
  // A/B/C map onto operator codes 1/2/3
  assign w_key_op   = 2'(keycode - 4'd9);

  // Digit accumulation on whichever operand is currently being entered
  logic [WIDTH-1:0] w_key_d;
  logic [WIDTH-1:0] w_cur_acc;
  logic [WIDTH-1:0] w_dig_acc;
  logic [CW-1:0]    w_dig_cnt;
  logic [CW-1:0]    w_first_cnt;
  assign w_key_d     = WIDTH'(keycode);
  assign w_cur_acc   = (r_state == S_ENTRY_B) ? r_acc_b : r_acc_a;
  assign w_first_cnt = (keycode != 4'd0) ? CW'(1) : '0;

  always_comb begin
    w_dig_acc = w_cur_acc;
    w_dig_cnt = r_digit_cnt;
    // Leading zeros neither change the value nor consume a digit slot
    if (!((keycode == 4'd0) && (w_cur_acc == '0)) && (r_digit_cnt < CW'(MAX_DIGITS))) begin
      w_dig_acc = w_cur_acc * WIDTH'(10) + w_key_d;
      w_dig_cnt = r_digit_cnt + CW'(1);
    end
  end

  // Single-cycle arithmetic, wide enough for the full product
  logic [LW-1:0]    w_a_ext, w_b_ext, w_res;
  logic             w_res_err;
  logic [WIDTH-1:0] w_res_val;
  assign w_a_ext = LW'(r_acc_a);
  assign w_b_ext = LW'(r_acc_b);

  always_comb begin
    w_res = w_a_ext;
    case (r_op)
      2'd1:    w_res = w_a_ext + w_b_ext;
      2'd2:    w_res = w_a_ext - w_b_ext;
      2'd3:    w_res = w_a_ext * w_b_ext;
      default: w_res = w_a_ext;
    endcase
  end

  assign w_res_err = ((r_op == 2'd2) && (r_acc_a < r_acc_b)) || (w_res > LW'(MAX_VALUE));
  assign w_res_val = WIDTH'(w_res);

  // Next-state and next-output logic
  always_comb begin
    w_nxt_state = r_state;
    w_nxt_acc_a = r_acc_a;
    w_nxt_acc_b = r_acc_b;
    w_nxt_cnt   = r_digit_cnt;
    w_nxt_op    = r_op;

    if (key_valid) begin
      if (w_is_ac) begin
        w_nxt_state = S_ENTRY_A;
        w_nxt_acc_a = '0;
        w_nxt_acc_b = '0;
        w_nxt_cnt   = '0;
        w_nxt_op    = 2'd0;
      end else begin
        case (r_state)
          S_ENTRY_A: begin
            if (w_is_digit) begin
              w_nxt_acc_a = w_dig_acc;
              w_nxt_cnt   = w_dig_cnt;
            end else if (w_is_op) begin
              w_nxt_op    = w_key_op;
              w_nxt_state = S_OP_PEND;
            end else if (w_is_ce) begin
              w_nxt_acc_a = '0;
              w_nxt_cnt   = '0;
            end
          end
          S_OP_PEND: begin
            if (w_is_digit) begin
              w_nxt_acc_b = w_key_d;
              w_nxt_cnt   = w_first_cnt;
              w_nxt_state = S_ENTRY_B;
            end else if (w_is_op) begin
              w_nxt_op = w_key_op;
            end
          end
          S_ENTRY_B: begin
            if (w_is_digit) begin
              w_nxt_acc_b = w_dig_acc;
              w_nxt_cnt   = w_dig_cnt;
            end else if (w_is_ce) begin
              w_nxt_acc_b = '0;
              w_nxt_cnt   = '0;
            end else if (w_is_eq || w_is_op) begin
              if (w_res_err) begin
                w_nxt_state = S_ERROR;
                w_nxt_acc_a = '0;
                w_nxt_acc_b = '0;
                w_nxt_cnt   = '0;
                w_nxt_op    = 2'd0;
              end else begin
                // Result becomes the left operand, both for display and chaining
                w_nxt_acc_a = w_res_val;
                w_nxt_cnt   = '0;
                if (w_is_eq) begin
                  w_nxt_state = S_RESULT;
                  w_nxt_op    = 2'd0;
                end else begin
                  w_nxt_state = S_OP_PEND;
                  w_nxt_op    = w_key_op;
                end
              end
            end
          end
          S_RESULT: begin
            if (w_is_digit) begin
              w_nxt_acc_a = w_key_d;
              w_nxt_cnt   = w_first_cnt;
              w_nxt_state = S_ENTRY_A;
            end else if (w_is_op) begin
              w_nxt_op    = w_key_op;
              w_nxt_state = S_OP_PEND;
            end else if (w_is_ce) begin
              w_nxt_acc_a = '0;
              w_nxt_cnt   = '0;
              w_nxt_state = S_ENTRY_A;
            end
          end
          S_ERROR: begin
            w_nxt_state = S_ERROR;
          end
          default: begin
            w_nxt_state = S_ENTRY_A;
            w_nxt_acc_a = '0;
            w_nxt_acc_b = '0;
            w_nxt_cnt   = '0;
            w_nxt_op    = 2'd0;
          end
        endcase
      end
    end

    // Outputs follow the state being entered so they land one cycle after the key
    w_nxt_display    = w_nxt_acc_a;
    w_nxt_error      = 1'b0;
    w_nxt_op_pending = 2'd0;
    case (w_nxt_state)
      S_ENTRY_B: begin
        w_nxt_display    = w_nxt_acc_b;
        w_nxt_op_pending = w_nxt_op;
      end
      S_OP_PEND: w_nxt_op_pending = w_nxt_op;
      S_ERROR: begin
        w_nxt_display = '0;
        w_nxt_error   = 1'b1;
      end
      default: w_nxt_display = w_nxt_acc_a;
    endcase
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (reset) begin
      r_state       <= S_ENTRY_A;
      r_acc_a       <= '0;
      r_acc_b       <= '0;
      r_digit_cnt   <= '0;
      r_op          <= 2'd0;
      display_value <= '0;
      error         <= 1'b0;
      op_pending    <= 2'd0;
      key_ack       <= 1'b0;
    end else begin
      r_state       <= w_nxt_state;
      r_acc_a       <= w_nxt_acc_a;
      r_acc_b       <= w_nxt_acc_b;
      r_digit_cnt   <= w_nxt_cnt;
      r_op          <= w_nxt_op;
      display_value <= w_nxt_display;
      error         <= w_nxt_error;
      op_pending    <= w_nxt_op_pending;
      key_ack       <= key_valid;
    end
  end

endmodule

// File: doc/calc_entry_fsm.md
Name: calc_entry_fsm

Overview:
- Calculator core between keypad_encoder and bin2bcd_10bit.
- Consumes one-cycle keycode strobes, assembles decimal operands and applies + − × on the operands.
- Drives a registered 10-bit value to the BCD/seven-segment path, with an error flag on overflow or negative result.

Parameters:
- MAX_DIGITS, 3, maximum decimal digits per operand; further digits are ignored.
- MAX_VALUE, 999, largest legal operand or result; anything above is an error.
- WIDTH, 10, width of operand, result and display registers; must satisfy 2^WIDTH > MAX_VALUE.

Ports:
- Clk  input  1  system clock (12 MHz board clock).
- reset  input  1  synchronous, active-high reset.
- key_valid  input  1  one-cycle strobe; keycode is valid in this cycle.
- keycode  input  4  0x0–0x9 digit; 0xA add; 0xB subtract; 0xC multiply; 0xD clear entry (CE); 0xE equals; 0xF all clear (AC).
- display_value  output  WIDTH  value for bin2bcd_10bit.
- error  output  1  high while in S_ERROR.
- op_pending  output  2  stored operator: 0 none, 1 add, 2 sub, 3 mul.
- key_ack  output  1  one-cycle pulse, one cycle after an accepted strobe.

Behaviour:
- Clock and reset
  - Single clock, Clk. All state changes only on posedge Clk.
  - Reset is synchronous active-high and overrides key_valid.
  - Reset values: state S_ENTRY_A, acc_a=0, acc_b=0, digit_cnt=0, op=0, display_value=0, error=0, op_pending=0, key_ack=0.
  - Reset mid-operation discards all operands.
- Timing
  - Keycode is sampled only when key_valid=1.
  - All outputs are registered and reflect the key in the cycle after the strobe; latency is 1 cycle.
  - Back-to-back strobes on consecutive cycles are each processed.
  - key_ack pulses for every strobe that is not dropped by reset, including ignored keys.
- Digit entry (applies to the current entry register: acc_a in S_ENTRY_A, acc_b in S_ENTRY_B)
  - acc ← acc*10 + d and digit_cnt++, only if digit_cnt < MAX_DIGITS; otherwise the digit is ignored.
  - Digit 0 while acc==0 leaves digit_cnt unchanged, so leading zeros do not count.
  - display_value shows the current entry register.
- States and transitions
  - S_ENTRY_A:
    - Digit → update acc_a.
    - Operator → op←key, go to S_OP_PEND, display acc_a.
    - CE → acc_a=0, digit_cnt=0.
    - Equals is ignored.
  - S_OP_PEND:
    - Digit → acc_b=d, digit_cnt=(d≠0), go to S_ENTRY_B.
    - Operator → replaces op.
    - CE and equals are ignored.
  - S_ENTRY_B:
    - Digit → update acc_b.
    - Equals → compute, go to S_RESULT.
    - Operator → compute (chaining): acc_a←result, op←new key, go to S_OP_PEND, display result.
    - CE → acc_b=0, digit_cnt=0, stay in S_ENTRY_B, display 0.
  - S_RESULT:
    - Digit → acc_a=d, start a new entry in S_ENTRY_A.
    - Operator → acc_a=result, go to S_OP_PEND.
    - CE → acc_a=0, go to S_ENTRY_A.
    - Equals is ignored.
  - S_ERROR:
    - display_value=0, error=1.
    - All keys except AC are ignored.
  - AC in any state is equivalent to reset, except key_ack=1.
- Arithmetic (single-cycle compute)
  - Sum on WIDTH+1 bits.
  - Difference signed; a negative result is an error.
  - Product on 2*WIDTH bits.
  - A result > MAX_VALUE or < 0 → go to S_ERROR, op cleared.
  - A result of exactly MAX_VALUE is legal.
- op_pending
  - Equals op in S_OP_PEND and S_ENTRY_B.
  - 0 in all other states.

Test Plan:
- Reset, then keys 1,2,3,4 → display 1, 12, 123, 123; the 4th digit is ignored. key_ack pulses 4 times, error=0.
- Keys 0,0,7,A,5,E → display 7 after 0,0,7; display 7 with op_pending=1 after A; 5; then 12, S_RESULT, op_pending=0.
- Chaining: keys 9,C,9,A,1,0,E → display 81 after the second A, then 91. Then key 3 → display 3, a fresh entry.
- Overflow and negative:
  - 5,0,0,A,5,0,0,E → error=1, display 0; then 1,A ignored; then F → display 0, error=0.
  - 3,B,4,E → error=1.
  - 9,9,9,A,0,E → 999, no error (boundary).
- CE / operator replace: 4,5,A,B,7,D,2,E → op_pending goes 1→2; B cleared to 0 then 2; result 43.
- Reset asserted together with key_valid=1 mid-entry (acc_b=12) → key dropped, all outputs 0 next cycle, key_ack=0; back-to-back strobes 1,2 on consecutive cycles → display 12.
